// File: rtl/lcd_update_ctrl_if.sv
// Bus bundle for lcd_update_ctrl: measurement input, converter handshake,
// and the committed readout towards lcd_display.
interface lcd_update_ctrl_if #(
  parameter int DATA_W = 30,
  parameter int DIGITS = 9
);
  logic [DATA_W-1:0]   data;
  logic                data_vld;
  logic                lcd_vs;
  logic                conv_req;
  logic [DATA_W-1:0]   conv_data;
  logic                conv_ack;
  logic [4*DIGITS-1:0] conv_bcd;
  logic [4*DIGITS-1:0] bcd_data;
  logic [DIGITS-1:0]   blank_mask;
  logic                overflow;
  logic                upd_pulse;

  // Controller side: consumes measurements and converter results, drives the readout.
  modport slave (
    input  data, data_vld, lcd_vs, conv_ack, conv_bcd,
    output conv_req, conv_data, bcd_data, blank_mask, overflow, upd_pulse
  );

  // Environment side: measurement core, converter and display driver.
  modport master (
    output data, data_vld, lcd_vs, conv_ack, conv_bcd,
    input  conv_req, conv_data, bcd_data, blank_mask, overflow, upd_pulse
  );
endinterface

// File: rtl/lcd_update_ctrl.sv
// Display refresh scheduler for the frequency readout. Latches the newest
// measurement, converts it through the shared binary-to-BCD unit, and commits
// the result to the display only on a frame boundary, at most once per
// FRAME_DIV frames, so the readout never tears.
module lcd_update_ctrl #(
  parameter int   DATA_W       = 30,
  parameter int   DIGITS       = 9,
  parameter int   FRAME_DIV    = 1,
  parameter int   CONV_TIMEOUT = 64,
  parameter logic VS_POL       = 1'b0
) (
  input  logic               lcd_pclk,
  input  logic               sys_rst_n,
  lcd_update_ctrl_if.slave   bus
);

  // Largest value the readout can show (all nines).
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0] BCD_MAX = pow10(DIGITS) - 64'd1;
  localparam int TMO_W   = (CONV_TIMEOUT > 1) ? $clog2(CONV_TIMEOUT) : 1;
  localparam int FRAME_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(CONV_TIMEOUT - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_DIV - 1);

  // Leading-zero blanking: digit i is blank when it and every digit above it
  // is zero; the units digit always shows.
  function automatic logic [DIGITS-1:0] blank_of(input logic [4*DIGITS-1:0] v);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    m          = {DIGITS{1'b0}};
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above & (v[4*i +: 4] == 4'd0);
      m[i]       = zero_above;
    end
    return m;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REQ        = 2'd1,
    ST_WAIT_FRAME = 2'd2,
    ST_COMMIT     = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  logic                pending_r;
  logic [DATA_W-1:0]   pending_data_r;
  logic                conv_req_r;
  logic [DATA_W-1:0]   conv_data_r;
  logic [TMO_W-1:0]    tmo_cnt_r;
  logic                vs_q_r;
  logic                vs_qq_r;
  logic [FRAME_W-1:0]  frame_cnt_r;
  logic [4*DIGITS-1:0] shadow_r;
  logic                ovf_shadow_r;
  logic [4*DIGITS-1:0] bcd_data_r;
  logic [DIGITS-1:0]   blank_mask_r;
  logic                overflow_r;
  logic                upd_pulse_r;

  logic                vs_edge_s;
  logic                frame_ok_s;
  logic                load_s;
  logic                take_ack_s;
  logic                timeout_s;
  logic                commit_s;
  logic [63:0]         pend_ext_s;
  logic [DATA_W-1:0]   clamp_data_s;
  logic                clamp_ovf_s;

  // Frame boundary: lcd_vs entering its active level, seen one cycle late.
  assign vs_edge_s  = (vs_q_r == VS_POL) && (vs_qq_r != VS_POL);
  assign frame_ok_s = (frame_cnt_r == FRAME_LAST);

  // Clamp the pending value to what the readout can display.
  always_comb begin
    pend_ext_s = {{(64-DATA_W){1'b0}}, pending_data_r};
    if (pend_ext_s > BCD_MAX) begin
      clamp_data_s = BCD_MAX[DATA_W-1:0];
      clamp_ovf_s  = 1'b1;
    end else begin
      clamp_data_s = pending_data_r;
      clamp_ovf_s  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge lcd_pclk) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and the one-cycle control strobes for the datapath.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    take_ack_s  = 1'b0;
    timeout_s   = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pending_r) begin
          state_nxt_s = ST_REQ;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.conv_ack) begin
          state_nxt_s = ST_WAIT_FRAME;
          take_ack_s  = 1'b1;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_nxt_s = ST_IDLE;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT_FRAME: begin
        if (vs_edge_s && frame_ok_s) begin
          state_nxt_s = ST_COMMIT;
          commit_s    = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_FRAME;
        end
      end
      ST_COMMIT: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Pending measurement: newest value wins; a timed-out request re-arms it.
  always_ff @(posedge lcd_pclk) begin
    if (!sys_rst_n) begin
      pending_r      <= 1'b0;
      pending_data_r <= {DATA_W{1'b0}};
    end else if (bus.data_vld) begin
      pending_r      <= 1'b1;
      pending_data_r <= bus.data;
    end else if (load_s) begin
      pending_r      <= 1'b0;
    end else if (timeout_s) begin
      pending_r      <= 1'b1;
    end else begin
      pending_r      <= pending_r;
    end
  end

  // Converter request: value frozen for the whole handshake.
  always_ff @(posedge lcd_pclk) begin
    if (!sys_rst_n) begin
      conv_req_r   <= 1'b0;
      conv_data_r  <= {DATA_W{1'b0}};
      ovf_shadow_r <= 1'b0;
    end else if (load_s) begin
      conv_req_r   <= 1'b1;
      conv_data_r  <= clamp_data_s;
      ovf_shadow_r <= clamp_ovf_s;
    end else if (take_ack_s || timeout_s) begin
      conv_req_r   <= 1'b0;
    end else begin
      conv_req_r   <= conv_req_r;
    end
  end

  // Cycles spent waiting for the converter in the current request.
  always_ff @(posedge lcd_pclk) begin
    if (!sys_rst_n) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if ((state_r == ST_REQ) && !take_ack_s && !timeout_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end
  end

  // Two-stage history of lcd_vs for edge detection.
  always_ff @(posedge lcd_pclk) begin
    if (!sys_rst_n) begin
      vs_q_r  <= ~VS_POL;
      vs_qq_r <= ~VS_POL;
    end else begin
      vs_q_r  <= bus.lcd_vs;
      vs_qq_r <= vs_q_r;
    end
  end

  // Frames since the last commit, saturating at the commit threshold.
  always_ff @(posedge lcd_pclk) begin
    if (!sys_rst_n) begin
      frame_cnt_r <= {FRAME_W{1'b0}};
    end else if (state_r == ST_COMMIT) begin
      frame_cnt_r <= {FRAME_W{1'b0}};
    end else if (vs_edge_s && !frame_ok_s) begin
      frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Converted result held until the next frame boundary allows a commit.
  always_ff @(posedge lcd_pclk) begin
    if (!sys_rst_n) begin
      shadow_r <= {(4*DIGITS){1'b0}};
    end else if (take_ack_s) begin
      shadow_r <= bus.conv_bcd;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Committed readout; all fields change together with the update strobe.
  always_ff @(posedge lcd_pclk) begin
    if (!sys_rst_n) begin
      bcd_data_r   <= {(4*DIGITS){1'b0}};
      blank_mask_r <= {{(DIGITS-1){1'b1}}, 1'b0};
      overflow_r   <= 1'b0;
      upd_pulse_r  <= 1'b0;
    end else begin
      upd_pulse_r <= commit_s;
      if (commit_s) begin
        bcd_data_r   <= shadow_r;
        blank_mask_r <= blank_of(shadow_r);
        overflow_r   <= ovf_shadow_r;
      end else begin
        bcd_data_r   <= bcd_data_r;
        blank_mask_r <= blank_mask_r;
        overflow_r   <= overflow_r;
      end
    end
  end

  assign bus.conv_req   = conv_req_r;
  assign bus.conv_data  = conv_data_r;
  assign bus.bcd_data   = bcd_data_r;
  assign bus.blank_mask = blank_mask_r;
  assign bus.overflow   = overflow_r;
  assign bus.upd_pulse  = upd_pulse_r;

endmodule
